// File: rtl/usb_tx_packet_if.sv
// usb_tx_packet_if
//   Groups the signals between the packet generator, the SIE/endpoint logic
//   and the bit-level transmitter.
//   Parameter: LEN_W - width of the payload length field.
//   Request  : start, pid, len          (SIE -> generator)
//   Payload  : pl_data, pl_valid, pl_ready (endpoint buffer <-> generator)
//   Transmit : tx_data, tx_valid, tx_ready, tx_en (generator <-> transmitter)
//   Status   : busy, done, err          (generator -> SIE)
//   modport master: the environment (SIE, endpoint buffer, transmitter).
//   modport slave : the packet generator.
interface usb_tx_packet_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [3:0]       pid;
  logic [LEN_W-1:0] len;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic             pl_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_en;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, pid, len, pl_data, pl_valid, tx_ready, tx_en,
    input  pl_ready, tx_data, tx_valid, busy, done, err
  );

  modport slave (
    input  start, pid, len, pl_data, pl_valid, tx_ready, tx_en,
    output pl_ready, tx_data, tx_valid, busy, done, err
  );
endinterface

// File: rtl/usb_tx_packet.sv
// usb_tx_packet
//   Low-speed USB packet generator feeding the SYNC/stuffing/NRZI/EOP stage.
//   Emits PID [payload CRC16-lo CRC16-hi] on the tx handshake and reports
//   done once the transmitter has released the line.
//   Ports:
//     clk   - system clock (24 MHz)
//     reset - synchronous, active-high
//     bus   - usb_tx_packet_if.slave (request, payload, transmit, status)
//   Parameters: MAX_LEN (max payload bytes), LEN_W (len width),
//               WDOG_CYCLES (watchdog limit).
//   Optional feature: define USB_TX_PKT_WDOG_EN to enable the stall
//   watchdog; without it the block waits indefinitely for tx_ready/tx_en.
//
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_PID      | PID byte presented, waiting for tx_ready
//   ST_PAYLOAD  | payload byte presented, waiting for tx_ready
//   ST_CRC_LO   | inverted CRC low byte presented
//   ST_CRC_HI   | inverted CRC high byte presented
//   ST_WAIT_EOP | tx_valid dropped, waiting for tx_en low (EOP finished)
module usb_tx_packet #(
  parameter int MAX_LEN     = 8,
  parameter int LEN_W       = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input logic            clk,
  input logic            reset,
  usb_tx_packet_if.slave bus
);

  if (MAX_LEN >= (1 << LEN_W) || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("usb_tx_packet: LEN_W too narrow for MAX_LEN or WDOG_CYCLES < 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_PAYLOAD, ST_CRC_LO, ST_CRC_HI, ST_WAIT_EOP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             is_data_q, is_data_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             pl_ready_c;
  logic             wdog_fire;

  // Reflected CRC16 (0xA001), one byte per clock, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction

`ifdef USB_TX_PKT_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Down-counter reloaded on progress; terminal count is zero.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_IDLE || bus.tx_ready || wdog_fire)
      wdog_q <= WDOG_W'(WDOG_CYCLES - 1);
    else if (wdog_q != '0)
      wdog_q <= wdog_q - WDOG_W'(1);
  end

  assign wdog_fire = (state_q != ST_IDLE) && (wdog_q == '0) && !bus.tx_ready;
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      crc_q      <= 16'hFFFF;
      count_q    <= '0;
      is_data_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      crc_q      <= crc_d;
      count_q    <= count_d;
      is_data_q  <= is_data_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    crc_d      = crc_q;
    count_d    = count_q;
    is_data_d  = is_data_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    pl_ready_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.pid[1:0] == 2'b11 && int'(bus.len) > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            tx_data_d  = {~bus.pid, bus.pid};
            tx_valid_d = 1'b1;
            crc_d      = 16'hFFFF;
            is_data_d  = (bus.pid[1:0] == 2'b11);
            count_d    = (bus.pid[1:0] == 2'b11) ? bus.len : '0;
            state_d    = ST_PID;
          end
        end
      end
      ST_PID, ST_PAYLOAD: begin
        if (bus.tx_ready) begin
          if (!is_data_q) begin
            tx_valid_d = 1'b0;
            state_d    = ST_WAIT_EOP;
          end else if (count_q != '0) begin
            // Next payload byte must be ready in the same cycle the current
            // byte is taken; otherwise the packet is cut short (underrun).
            if (bus.pl_valid) begin
              pl_ready_c = 1'b1;
              tx_data_d  = bus.pl_data;
              crc_d      = crc16_byte(crc_q, bus.pl_data);
              count_d    = count_q - LEN_W'(1);
              state_d    = ST_PAYLOAD;
            end else begin
              err_d      = 1'b1;
              tx_valid_d = 1'b0;
              state_d    = ST_WAIT_EOP;
            end
          end else begin
            tx_data_d = ~crc_q[7:0];
            state_d   = ST_CRC_LO;
          end
        end
      end
      ST_CRC_LO: begin
        if (bus.tx_ready) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (!bus.tx_en) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wdog_fire) begin
      err_d      = 1'b1;
      done_d     = 1'b0;
      pl_ready_c = 1'b0;
      tx_valid_d = 1'b0;
      state_d    = (state_q == ST_WAIT_EOP) ? ST_IDLE : ST_WAIT_EOP;
    end
  end

  // pl_ready is combinational; masked during reset so no byte is consumed.
  assign bus.pl_ready = pl_ready_c & ~reset;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: doc/usb_tx_packet.md
Name: usb_tx_packet

Overview:
Low-speed USB packet generator sitting directly upstream of the bit-level transmitter (SYNC/stuffing/NRZI/EOP stage). It accepts a PID and an optional payload stream from the SIE/endpoint logic. It emits the byte sequence PID [payload CRC16-lo CRC16-hi] on the transmitter's data/valid/ready handshake. It signals completion once the transmitter has finished EOP.

Parameters:
MAX_LEN, 8, maximum payload bytes per data packet (low-speed limit)
LEN_W, 4, width of len port; must hold MAX_LEN
WDOG_CYCLES, 4096, watchdog limit in clk cycles; used only with USB_TX_PKT_WDOG_EN

Ports:
clk  input  1  system clock (24 MHz)
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to send a packet; sampled only in IDLE
pid  input  4  packet ID, sampled with start
len  input  LEN_W  payload byte count, sampled with start; ignored for non-data PIDs
pl_data  input  8  payload byte from endpoint buffer
pl_valid  input  1  pl_data holds a valid byte
pl_ready  output  1  one-cycle pulse: pl_data consumed this cycle
tx_data  output  8  byte to transmitter
tx_valid  output  1  high for the whole packet; falling edge requests EOP
tx_ready  input  1  transmitter pulse: tx_data latched this cycle
tx_en  input  1  transmitter output-enable (line driven)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the packet has left the line
err  output  1  one-cycle pulse on underrun, bad len, or watchdog

Behaviour:
- Reset values: tx_data=8'h00, tx_valid=0, pl_ready=0, busy=0, done=0, err=0, state=IDLE, crc=16'hFFFF.
- PID byte = {~pid, pid}; the transmitter sends it LSB first.
- Data PIDs: pid[1:0]==2'b11 (DATA0/DATA1/DATA2/MDATA). All other PIDs are PID-only packets.
- States: IDLE, PID, PAYLOAD, CRC_LO, CRC_HI, WAIT_EOP.
- IDLE + start:
  - Data PID with len>MAX_LEN: pulse err next cycle, remain IDLE, send nothing.
  - Otherwise, next cycle: tx_data=PID byte, tx_valid=1, crc=16'hFFFF, byte counter=len, go PID.
- start outside IDLE is ignored.
- In PID/PAYLOAD/CRC_LO/CRC_HI, tx_data is held stable until tx_ready. On tx_ready, advance on the next clock:
  - PID, non-data PID -> tx_valid=0, WAIT_EOP.
  - PID or PAYLOAD, data PID with count>0 -> needs a payload byte in the same cycle as tx_ready:
    - pl_valid=1: pl_ready=1 (same cycle, combinational); tx_data<=pl_data; crc updated over pl_data (8 bits, LSB first, one cycle); count-1; state PAYLOAD.
    - pl_valid=0 (underrun): err pulse, tx_valid=0, WAIT_EOP. The truncated packet fails CRC at the host.
  - PID or PAYLOAD, count==0 -> tx_data=~crc[7:0], CRC_LO.
  - CRC_LO -> tx_data=~crc[15:8], CRC_HI.
  - CRC_HI -> tx_valid=0, WAIT_EOP.
- CRC16 definition: poly x^16+x^15+x^2+1, reflected form 0xA001, init FFFF, result inverted, low byte sent first.
- Zero-length data packet sends CRC bytes 00 00.
- WAIT_EOP: when tx_en==0, pulse done and go IDLE (busy drops the same cycle as done).
- pl_ready never asserts outside a tx_ready cycle. At most len pl_ready pulses are issued per packet.
- Reset mid-packet: all outputs return to reset values next cycle. tx_valid drop causes the transmitter to EOP.

Optional Feature:
Macro USB_TX_PKT_WDOG_EN.
- Defined: a counter clears on every tx_ready and in IDLE. If it reaches WDOG_CYCLES in any state other than IDLE or WAIT_EOP: tx_valid=0, err pulse, go WAIT_EOP. In WAIT_EOP, reaching WDOG_CYCLES forces IDLE with err pulse and no done.
- Undefined: no counter; the block waits indefinitely for tx_ready/tx_en.

Test Plan:
- ACK (pid=0010): tx_data=D2 on first tx_ready, then tx_valid falls; done after tx_en low; zero pl_ready pulses.
- DATA1 len=0: byte sequence 4B,00,00, then tx_valid low, then done.
- DATA0 len=1 pl_data=00: sequence C3,00,40,BF; exactly one pl_ready, coincident with the first tx_ready.
- DATA0 len=3, pl_valid dropped at the 2nd payload request: sequence C3,b0 then tx_valid low; err pulse; done still follows tx_en low.
- len=9 with MAX_LEN=8 on a DATA PID: err pulse, tx_valid stays 0, busy stays 0. Also: start asserted while busy is ignored.
- Reset asserted mid-PAYLOAD: next cycle tx_valid=0, busy=0, state IDLE. A following DATA1 len=0 packet produces 4B,00,00 correctly (CRC re-initialised).
